vga_rect_fill_writer: RTL and testbench
=======================================

// Module: vga_rect_fill_writer
// PURPOSE
//   Write-side engine for the dual-port VGA frame RAM. The VGA_Control scan
//   path owns the read port; this block owns the write port
//   (iWriteEnable / iWriteRow / iWriteCol / RGB_in).
//   It accepts one rectangle-fill or full-frame-clear command per handshake.
//   It then writes one pixel per clock, row-major, clipped to the frame limits.
//   The MiniAlu datapath issues the commands (VGA write instruction).
// PARAMETERS
//   DATA_WIDTH  3    pixel colour width {R,G,B}
//   ADD_WIDTH   8    row and column address width (same for both)
//   ROW_LIMIT   255  last valid row index; rows above it are never written
//   COL_LIMIT   255  last valid column index; columns above it are never written
// PORTS
//   Clock          in   1           single clock (25 MHz pixel-domain clock in MiniAlu)
//   Reset          in   1           asynchronous, active-high
//   iCmdValid      in   1           command present on iRow..iClear
//   oCmdReady      out  1           high only in IDLE; command accepted when iCmdValid & oCmdReady at posedge
//   iClear         in   1           1: fill whole frame; iRow/iCol/iWidth/iHeight ignored
//   iRow           in   ADD_WIDTH   top row of rectangle
//   iCol           in   ADD_WIDTH   left column of rectangle
//   iWidth         in   ADD_WIDTH   columns in rectangle (0 = empty)
//   iHeight        in   ADD_WIDTH   rows in rectangle (0 = empty)
//   iColor         in   DATA_WIDTH  fill colour
//   oWriteEnable   out  1           frame-RAM write strobe, one pixel per cycle
//   oWriteRow      out  ADD_WIDTH   frame-RAM write row
//   oWriteCol      out  ADD_WIDTH   frame-RAM write column
//   oRGB           out  DATA_WIDTH  frame-RAM write data
//   oBusy          out  1           high in FILL and DONE
//   oDone          out  1           one-cycle pulse after the last write of a command
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE. oWriteEnable, oWriteRow, oWriteCol,
//     oRGB, oBusy and oDone all go to 0. oCmdReady=1. An in-progress fill is
//     aborted with no further writes.
//   - All outputs are registered except oCmdReady, which is (state==IDLE).
//   - FSM states: IDLE, FILL, DONE.
//   - IDLE, on accept:
//     - Latch the command. Compute the clipped bounds in ADD_WIDTH+1 bits so
//       nothing wraps:
//       rEnd = min(iRow+iHeight-1, ROW_LIMIT)
//       cEnd = min(iCol+iWidth-1, COL_LIMIT)
//     - Clear commands use rows 0..ROW_LIMIT and cols 0..COL_LIMIT.
//     - Empty command goes to DONE: iWidth==0, iHeight==0, iRow>ROW_LIMIT or iCol>COL_LIMIT.
//     - Any other command goes to FILL, with the pixel cursor at (start row, start col).
//   - FILL:
//     - Every cycle, oWriteEnable=1 with the current cursor and the latched colour.
//     - The cursor advances column-first. At cEnd the column returns to the
//       start column and the row increments.
//     - At (rEnd, cEnd), go to DONE.
//     - Latency: the first write is in the cycle after acceptance. A command of
//       N clipped pixels gives exactly N consecutive write cycles, with no bubbles.
//   - DONE: oWriteEnable=0, oDone=1 for exactly one cycle, then IDLE.
//     oCmdReady returns high in the following cycle.
//   - Commands presented while not IDLE are ignored (not queued).
//     iCmdValid may stay high; it is re-sampled only in IDLE.
//   - Command inputs may change after acceptance without affecting the fill in progress.
//   - oWriteRow/oWriteCol/oRGB hold their last values while oWriteEnable=0.
// TESTING
//   1. Rect row=10 col=20 w=3 h=2 colour=5 -> 6 consecutive writes
//      (10,20),(10,21),(10,22),(11,20),(11,21),(11,22), all RGB=5.
//      oDone is high in the cycle after the 6th write; oCmdReady=1 one cycle later.
//   2. w=0 h=7 -> no writes; oDone is pulsed in the cycle after acceptance.
//      Repeat with iRow=ROW_LIMIT+1 -> same response.
//   3. Clip: row=100 col=254 w=4 h=1 (COL_LIMIT=255) -> exactly 2 writes,
//      (100,254) and (100,255); no column wrap to 0/1.
//   4. Clear with ROW_LIMIT=3 COL_LIMIT=3 colour=2 -> 16 writes, (0,0)..(3,3)
//      row-major, then oDone.
//   5. Busy: a second command held valid during test 1's fill -> ignored,
//      oCmdReady=0 throughout the fill. The second command is accepted in the
//      first IDLE cycle after oDone.
//   6. Async Reset asserted mid-fill (after 3 writes of test 1) -> oWriteEnable
//      drops immediately, with no further writes. After release, oCmdReady=1
//      and a new command runs normally.

Source files
------------

// File: rtl/vga_rect_fill_writer_if.sv
// Command and frame-RAM write-port bundle for the rectangle fill writer.
// The master side (MiniAlu datapath) issues commands and observes the write port;
// the slave side (fill writer) accepts commands and drives the write port.
interface vga_rect_fill_writer_if #(
    parameter int DATA_WIDTH = 3,
    parameter int ADD_WIDTH  = 8
);
    logic                  iCmdValid;
    logic                  oCmdReady;
    logic                  iClear;
    logic [ADD_WIDTH-1:0]  iRow;
    logic [ADD_WIDTH-1:0]  iCol;
    logic [ADD_WIDTH-1:0]  iWidth;
    logic [ADD_WIDTH-1:0]  iHeight;
    logic [DATA_WIDTH-1:0] iColor;
    logic                  oWriteEnable;
    logic [ADD_WIDTH-1:0]  oWriteRow;
    logic [ADD_WIDTH-1:0]  oWriteCol;
    logic [DATA_WIDTH-1:0] oRGB;
    logic                  oBusy;
    logic                  oDone;

    modport master (
        output iCmdValid, iClear, iRow, iCol, iWidth, iHeight, iColor,
        input  oCmdReady, oWriteEnable, oWriteRow, oWriteCol, oRGB, oBusy, oDone
    );

    modport slave (
        input  iCmdValid, iClear, iRow, iCol, iWidth, iHeight, iColor,
        output oCmdReady, oWriteEnable, oWriteRow, oWriteCol, oRGB, oBusy, oDone
    );
endinterface

// File: rtl/vga_rect_fill_writer.sv
// Write-side engine for the dual-port VGA frame RAM: accepts one rectangle-fill
// or full-frame-clear command, then writes one clipped pixel per clock, row-major.
module vga_rect_fill_writer #(
    parameter int DATA_WIDTH = 3,
    parameter int ADD_WIDTH  = 8,
    parameter int ROW_LIMIT  = 255,
    parameter int COL_LIMIT  = 255
) (
    input  logic                    Clock,
    input  logic                    Reset,
    vga_rect_fill_writer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Limits in ADD_WIDTH+1 bits so that row+height-1 never wraps before clipping
    localparam logic [ADD_WIDTH:0]   ROW_LIM = (ADD_WIDTH+1)'(ROW_LIMIT);
    localparam logic [ADD_WIDTH:0]   COL_LIM = (ADD_WIDTH+1)'(COL_LIMIT);
    localparam logic [ADD_WIDTH-1:0] ROW_END = ADD_WIDTH'(ROW_LIMIT);
    localparam logic [ADD_WIDTH-1:0] COL_END = ADD_WIDTH'(COL_LIMIT);
    localparam logic [ADD_WIDTH:0]   ONE     = (ADD_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADD_WIDTH-1:0]  row_q, row_d;
    logic [ADD_WIDTH-1:0]  col_q, col_d;
    logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADD_WIDTH-1:0]  start_col_q, start_col_d;
    logic [ADD_WIDTH-1:0]  r_end_q, r_end_d;
    logic [ADD_WIDTH-1:0]  c_end_q, c_end_d;

    logic [ADD_WIDTH:0]    row_sum;
    logic [ADD_WIDTH:0]    col_sum;
    logic [ADD_WIDTH-1:0]  row_clip;
    logic [ADD_WIDTH-1:0]  col_clip;
    logic                  cmd_empty;

    // Clipped inclusive end bounds and emptiness of the presented command
    always_comb begin
        row_sum   = {1'b0, bus.iRow} + {1'b0, bus.iHeight} - ONE;
        col_sum   = {1'b0, bus.iCol} + {1'b0, bus.iWidth} - ONE;
        row_clip  = (row_sum > ROW_LIM) ? ROW_END : row_sum[ADD_WIDTH-1:0];
        col_clip  = (col_sum > COL_LIM) ? COL_END : col_sum[ADD_WIDTH-1:0];
        cmd_empty = (bus.iWidth == '0) || (bus.iHeight == '0) ||
                    ({1'b0, bus.iRow} > ROW_LIM) || ({1'b0, bus.iCol} > COL_LIM);
    end

    // Next-state and next-output logic; the output registers double as the pixel cursor
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        row_d       = row_q;
        col_d       = col_q;
        rgb_d       = rgb_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_col_d = start_col_q;
        r_end_d     = r_end_q;
        c_end_d     = c_end_q;
        case (state_q)
            IDLE: begin
                if (bus.iCmdValid) begin
                    busy_d = 1'b1;
                    if (bus.iClear) begin
                        start_col_d = '0;
                        r_end_d     = ROW_END;
                        c_end_d     = COL_END;
                        row_d       = '0;
                        col_d       = '0;
                        rgb_d       = bus.iColor;
                        we_d        = 1'b1;
                        state_d     = FILL;
                    end else if (cmd_empty) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        start_col_d = bus.iCol;
                        r_end_d     = row_clip;
                        c_end_d     = col_clip;
                        row_d       = bus.iRow;
                        col_d       = bus.iCol;
                        rgb_d       = bus.iColor;
                        we_d        = 1'b1;
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                if ((row_q == r_end_q) && (col_q == c_end_q)) begin
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (col_q == c_end_q) begin
                    col_d = start_col_q;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                we_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous abort
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            rgb_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_col_q <= '0;
            r_end_q     <= '0;
            c_end_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rgb_q       <= rgb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_col_q <= start_col_d;
            r_end_q     <= r_end_d;
            c_end_q     <= c_end_d;
        end
    end

    assign bus.oCmdReady    = (state_q == IDLE);
    assign bus.oWriteEnable = we_q;
    assign bus.oWriteRow    = row_q;
    assign bus.oWriteCol    = col_q;
    assign bus.oRGB         = rgb_q;
    assign bus.oBusy        = busy_q;
    assign bus.oDone        = done_q;
endmodule

// File: tb/tb_vga_rect_fill_writer.sv
// Bench for vga_rect_fill_writer: a full-size instance (limits 255) and a small
// instance (limits 3), checked cycle by cycle against a pixel-list model.
module tb_vga_rect_fill_writer;
    logic clk;
    logic rst;

    vga_rect_fill_writer_if #(.DATA_WIDTH(3), .ADD_WIDTH(8)) bus ();
    vga_rect_fill_writer_if #(.DATA_WIDTH(3), .ADD_WIDTH(8)) sbus ();

    vga_rect_fill_writer #(
        .DATA_WIDTH(3), .ADD_WIDTH(8), .ROW_LIMIT(255), .COL_LIMIT(255)
    ) dut (
        .Clock(clk), .Reset(rst), .bus(bus)
    );

    vga_rect_fill_writer #(
        .DATA_WIDTH(3), .ADD_WIDTH(8), .ROW_LIMIT(3), .COL_LIMIT(3)
    ) sdut (
        .Clock(clk), .Reset(rst), .bus(sbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_q[$];
    int last_row[2];
    int last_col[2];
    int last_rgb[2];

    function automatic logic [31:0] pk(bit we, int r, int c, int rgb, bit busy, bit done, bit rdy);
        return {9'b0, we, 8'(r), 8'(c), 3'(rgb), busy, done, rdy};
    endfunction

    function automatic logic [31:0] obs(int sel);
        if (sel == 0)
            return {9'b0, bus.oWriteEnable, bus.oWriteRow, bus.oWriteCol, bus.oRGB,
                    bus.oBusy, bus.oDone, bus.oCmdReady};
        else
            return {9'b0, sbus.oWriteEnable, sbus.oWriteRow, sbus.oWriteCol, sbus.oRGB,
                    sbus.oBusy, sbus.oDone, sbus.oCmdReady};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic drive(int sel, bit v, bit clr, int row, int col, int w, int h, int color);
        if (sel == 0) begin
            bus.iCmdValid = v; bus.iClear = clr;
            bus.iRow = 8'(row); bus.iCol = 8'(col);
            bus.iWidth = 8'(w); bus.iHeight = 8'(h); bus.iColor = 3'(color);
        end else begin
            sbus.iCmdValid = v; sbus.iClear = clr;
            sbus.iRow = 8'(row); sbus.iCol = 8'(col);
            sbus.iWidth = 8'(w); sbus.iHeight = 8'(h); sbus.iColor = 3'(color);
        end
    endtask

    // Expected pixel list: every in-frame pixel of the rectangle, row-major
    task automatic build_exp(int sel, bit clr, int row, int col, int w, int h);
        int lim;
        lim = (sel == 0) ? 255 : 3;
        exp_q.delete();
        if (clr) begin
            for (int r = 0; r <= lim; r++)
                for (int c = 0; c <= lim; c++)
                    exp_q.push_back(r * 256 + c);
        end else begin
            for (int r = row; r < row + h; r++)
                for (int c = col; c < col + w; c++)
                    if (r <= lim && c <= lim)
                        exp_q.push_back(r * 256 + c);
        end
    endtask

    // Present a command to an idle DUT, let it be accepted, then scramble the inputs
    task automatic issue(int sel, bit clr, int row, int col, int w, int h, int color, string tag);
        drive(sel, 1'b1, clr, row, col, w, h, color);
        check({tag, " idle"}, obs(sel), pk(0, last_row[sel], last_col[sel], last_rgb[sel], 0, 0, 1));
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
    endtask

    // Check every cycle from the acceptance edge until ready returns
    task automatic collect(int sel, bit clr, int row, int col, int w, int h, int color, string tag);
        int n;
        logic [31:0] e;
        build_exp(sel, clr, row, col, w, h);
        n = exp_q.size();
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            if (k <= n) begin
                last_row[sel] = exp_q[k-1] / 256;
                last_col[sel] = exp_q[k-1] % 256;
                last_rgb[sel] = color;
                e = pk(1, last_row[sel], last_col[sel], color, 1, 0, 0);
            end else if (k == n + 1) begin
                e = pk(0, last_row[sel], last_col[sel], last_rgb[sel], 1, 1, 0);
            end else begin
                e = pk(0, last_row[sel], last_col[sel], last_rgb[sel], 0, 0, 1);
            end
            check($sformatf("%s cyc%0d", tag, k), obs(sel), e);
        end
    endtask

    task automatic run(int sel, bit clr, int row, int col, int w, int h, int color, string tag);
        issue(sel, clr, row, col, w, h, color, tag);
        collect(sel, clr, row, col, w, h, color, tag);
    endtask

    initial begin
        int r, c, w, h, col;
        bit clr;
        for (int i = 0; i < 2; i++) begin
            last_row[i] = 0; last_col[i] = 0; last_rgb[i] = 0;
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("reset big", obs(0), pk(0, 0, 0, 0, 0, 0, 1));
        check("reset small", obs(1), pk(0, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic 3x2 rectangle, with a second command held valid throughout
        issue(0, 0, 10, 20, 3, 2, 5, "rect");
        drive(0, 1, 0, 50, 60, 2, 2, 3);
        collect(0, 0, 10, 20, 3, 2, 5, "rect");
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        collect(0, 0, 50, 60, 2, 2, 3, "queued");

        // Empty commands
        run(0, 0, 5, 5, 0, 7, 4, "w0");
        run(0, 0, 5, 5, 7, 0, 4, "h0");
        run(1, 0, 4, 0, 2, 2, 1, "rowoob");
        run(1, 0, 0, 4, 2, 2, 1, "coloob");

        // Clipping at the right and bottom edges
        run(0, 0, 100, 254, 4, 1, 6, "clipc");
        run(0, 0, 254, 7, 1, 5, 1, "clipr");
        run(0, 0, 255, 255, 255, 255, 7, "corner");

        // Clear on the small frame; rectangle fields would be empty if not ignored
        run(1, 1, 7, 1, 0, 0, 2, "clear");

        // Randomized rectangles near and away from the frame edges
        for (int i = 0; i < 12; i++) begin
            r = (i % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(245, 255);
            col = (i % 3 == 0) ? $urandom_range(0, 255) : $urandom_range(248, 255);
            w = $urandom_range(0, 12);
            h = $urandom_range(0, 5);
            run(0, 0, r, col, w, h, $urandom_range(0, 7), $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            clr = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 5);
            c = $urandom_range(0, 5);
            run(1, clr, r, c, $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 7), $sformatf("srnd%0d", i));
        end

        // Asynchronous reset after three writes of a fill
        issue(0, 0, 10, 20, 3, 2, 5, "abort");
        build_exp(0, 0, 10, 20, 3, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort cyc%0d", k + 1), obs(0),
                  pk(1, exp_q[k] / 256, exp_q[k] % 256, 5, 1, 0, 0));
        end
        #2;
        rst = 1'b1;
        #1;
        check("abort now", obs(0), pk(0, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("abort hold%0d", k), obs(0), pk(0, 0, 0, 0, 0, 0, 1));
        end
        check("abort small", obs(1), pk(0, 0, 0, 0, 0, 0, 1));
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_row[i] = 0; last_col[i] = 0; last_rgb[i] = 0;
        end
        run(0, 0, 10, 20, 3, 2, 5, "after");
        run(1, 0, 2, 1, 3, 3, 6, "safter");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
